regfile_wb_arbiter: RTL and testbench

Write-back arbiter and scheduler for the 32×32 register file. It shares the file's single write port among N_REQ requesters (ALU write-back, load write-back, debug host) using round-robin arbitration with a valid/ready handshake. It stages the granted write for one cycle and forwards the staged value to both read ports, so a read never returns stale data while a write is still pending. It sits between the execution/memory stages and the register file.

---
 rtl/regfile_pkg.sv | 16 +
 rtl/regfile_wb_arbiter_if.sv | 37 +++
 rtl/regfile_wb_arbiter_rr_arbiter.sv | 49 ++++
 rtl/regfile_wb_arbiter.sv | 67 ++++++
 tb/tb_regfile_wb_arbiter.sv | 193 +++++++++++++++++++
 5 files changed

// File: rtl/regfile_pkg.sv
// Shared register-file constants and the write-request payload used by
// the write-back arbiter.
package regfile_pkg;

  localparam int unsigned NREG = 32;
  localparam int unsigned AW   = $clog2(NREG);
  localparam int unsigned DW   = 32;

  localparam logic [AW-1:0] ZERO_REG = '0;

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } wr_req_t;

endpackage

// File: rtl/regfile_wb_arbiter_if.sv
// Write-back requester bus, register-file write port and bypassed read ports.
interface regfile_wb_arbiter_if #(
  parameter int unsigned N_REQ = 3
);
  import regfile_pkg::*;

  logic                  stall;
  logic [N_REQ-1:0]      req_valid;
  logic [N_REQ*AW-1:0]   req_addr;
  logic [N_REQ*DW-1:0]   req_data;
  logic [N_REQ-1:0]      req_ready;
  logic                  rf_we;
  logic [AW-1:0]         rf_waddr;
  logic [DW-1:0]         rf_wdata;
  logic [AW-1:0]         rd_addr_A;
  logic [AW-1:0]         rd_addr_B;
  logic [DW-1:0]         rf_rdata_A;
  logic [DW-1:0]         rf_rdata_B;
  logic [DW-1:0]         rdata_A;
  logic [DW-1:0]         rdata_B;
  logic [N_REQ-1:0]      last_grant;

  modport slave (
    input  stall, req_valid, req_addr, req_data,
    input  rd_addr_A, rd_addr_B, rf_rdata_A, rf_rdata_B,
    output req_ready, rf_we, rf_waddr, rf_wdata,
    output rdata_A, rdata_B, last_grant
  );

  modport master (
    output stall, req_valid, req_addr, req_data,
    output rd_addr_A, rd_addr_B, rf_rdata_A, rf_rdata_B,
    input  req_ready, rf_we, rf_waddr, rf_wdata,
    input  rdata_A, rdata_B, last_grant
  );

endinterface

// File: rtl/regfile_wb_arbiter_rr_arbiter.sv
// Generic round-robin arbiter: one-hot grant searched upward from ptr,
// ptr moves past the winner only when the grant is actually taken.
module rr_arbiter #(
  parameter int unsigned N = 3
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] req,
  input  logic         en,
  input  logic         hs,
  output logic [N-1:0] grant
);

  localparam int unsigned PW = (N > 1) ? $clog2(N) : 1;

  logic [PW-1:0] ptr;
  logic [PW-1:0] idx;
  logic [PW-1:0] cand;
  logic [31:0]   pos;
  logic          found;

  // First requester at or after ptr, wrapping.
  always_comb begin
    grant = '0;
    idx   = ptr;
    found = 1'b0;
    pos   = '0;
    cand  = '0;
    for (int unsigned k = 0; k < N; k++) begin
      pos = 32'(ptr) + k;
      if (pos >= N) pos = pos - N;
      cand = PW'(pos);
      if (en && !found && req[cand]) begin
        found       = 1'b1;
        idx         = cand;
        grant[cand] = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr <= '0;
    end else if (hs) begin
      ptr <= (idx == PW'(N - 1)) ? '0 : idx + PW'(1);
    end
  end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Register-file write-back arbiter: round-robin grant, one-cycle write stage,
// and stage-to-read-port bypass so reads never see a stale value.
module regfile_wb_arbiter
  import regfile_pkg::*;
#(
  parameter int unsigned N_REQ = 3
) (
  input logic                  clk,
  input logic                  rst,
  regfile_wb_arbiter_if.slave  bus
);

  logic [N_REQ-1:0] grant;
  logic             hs;
  wr_req_t          sel;

  logic             stage_we;
  wr_req_t          stage_req;
  logic [N_REQ-1:0] stage_grant;

  rr_arbiter #(.N(N_REQ)) u_arb (
    .clk   (clk),
    .rst   (rst),
    .req   (bus.req_valid),
    .en    (!bus.stall),
    .hs    (hs),
    .grant (grant)
  );

  assign bus.req_ready = grant;
  assign hs            = |(bus.req_valid & grant);

  // Payload of the granted requester.
  always_comb begin
    sel = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (grant[i]) begin
        sel.addr = bus.req_addr[i*AW +: AW];
        sel.data = bus.req_data[i*DW +: DW];
      end
    end
  end

  // Stage drains every cycle; addr/data hold when idle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stage_we    <= 1'b0;
      stage_req   <= '0;
      stage_grant <= '0;
    end else begin
      stage_we    <= hs && (sel.addr != ZERO_REG);
      stage_grant <= hs ? grant : '0;
      if (hs) stage_req <= sel;
    end
  end

  assign bus.rf_we      = stage_we;
  assign bus.rf_waddr   = stage_req.addr;
  assign bus.rf_wdata   = stage_req.data;
  assign bus.last_grant = stage_grant;

  assign bus.rdata_A = (stage_we && stage_req.addr == bus.rd_addr_A && bus.rd_addr_A != ZERO_REG)
                       ? stage_req.data : bus.rf_rdata_A;
  assign bus.rdata_B = (stage_we && stage_req.addr == bus.rd_addr_B && bus.rd_addr_B != ZERO_REG)
                       ? stage_req.data : bus.rf_rdata_B;

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed bench for regfile_wb_arbiter with hand-computed expectations.
module tb_regfile_wb_arbiter;
  import regfile_pkg::*;

  localparam int unsigned N_REQ = 3;

  logic clk;
  logic rst;
  int   tests;
  int   failed;

  regfile_wb_arbiter_if #(.N_REQ(N_REQ)) bus ();

  regfile_wb_arbiter #(.N_REQ(N_REQ)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      failed++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic set_req(input int i, input logic [AW-1:0] a, input logic [DW-1:0] d);
    bus.req_addr[i*AW +: AW] = a;
    bus.req_data[i*DW +: DW] = d;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    tests  = 0;
    failed = 0;
    rst            = 1'b1;
    bus.stall      = 1'b0;
    bus.req_valid  = '0;
    bus.req_addr   = '0;
    bus.req_data   = '0;
    bus.rd_addr_A  = '0;
    bus.rd_addr_B  = '0;
    bus.rf_rdata_A = '0;
    bus.rf_rdata_B = '0;

    // Reset state
    #1;
    chk("reset_rf_we", 64'(bus.rf_we), 64'd0);
    chk("reset_last_grant", 64'(bus.last_grant), 64'd0);
    chk("reset_rf_waddr", 64'(bus.rf_waddr), 64'd0);
    chk("reset_rf_wdata", 64'(bus.rf_wdata), 64'd0);
    chk("reset_ready", 64'(bus.req_ready), 64'd0);
    step();
    step();
    rst = 1'b0;
    step();
    chk("idle_rf_we", 64'(bus.rf_we), 64'd0);
    chk("idle_last_grant", 64'(bus.last_grant), 64'd0);

    // Round robin with all three valid
    set_req(0, 5'd1, 32'hA);
    set_req(1, 5'd2, 32'hB);
    set_req(2, 5'd3, 32'hC);
    bus.req_valid = 3'b111;
    for (int c = 0; c < 6; c++) begin
      #1;
      chk($sformatf("rr_ready_%0d", c), 64'(bus.req_ready), 64'(3'b001 << (c % 3)));
      step();
      chk($sformatf("rr_we_%0d", c), 64'(bus.rf_we), 64'd1);
      chk($sformatf("rr_waddr_%0d", c), 64'(bus.rf_waddr), 64'((c % 3) + 1));
      chk($sformatf("rr_wdata_%0d", c), 64'(bus.rf_wdata), 64'(32'hA + (c % 3)));
      chk($sformatf("rr_last_%0d", c), 64'(bus.last_grant), 64'(3'b001 << (c % 3)));
    end
    bus.req_valid = '0;
    #1;
    chk("novalid_ready", 64'(bus.req_ready), 64'd0);
    step();
    chk("novalid_we", 64'(bus.rf_we), 64'd0);
    chk("novalid_last", 64'(bus.last_grant), 64'd0);

    // Bypass: requester 1 writes r5 (ptr=0 -> first valid is 1)
    set_req(1, 5'd5, 32'hDEADBEEF);
    bus.req_valid = 3'b010;
    #1;
    chk("byp_ready", 64'(bus.req_ready), 64'(3'b010));
    step();
    bus.req_valid  = '0;
    bus.rd_addr_A  = 5'd5;
    bus.rf_rdata_A = 32'h0;
    bus.rd_addr_B  = 5'd6;
    bus.rf_rdata_B = 32'h55;
    #1;
    chk("byp_rdata_A", 64'(bus.rdata_A), 64'(32'hDEADBEEF));
    chk("byp_rdata_B", 64'(bus.rdata_B), 64'(32'h55));
    chk("byp_waddr", 64'(bus.rf_waddr), 64'd5);

    // r0 write from requester 0 (ptr=2 -> wraps to 0)
    set_req(0, 5'd0, 32'h1234);
    bus.req_valid  = 3'b001;
    bus.rd_addr_A  = 5'd0;
    bus.rf_rdata_A = 32'h77;
    #1;
    chk("r0_ready", 64'(bus.req_ready), 64'(3'b001));
    step();
    bus.req_valid = '0;
    #1;
    chk("r0_we", 64'(bus.rf_we), 64'd0);
    chk("r0_last", 64'(bus.last_grant), 64'(3'b001));
    chk("r0_rdata_A", 64'(bus.rdata_A), 64'(32'h77));

    // Stall: write staged before stall still drains (ptr=1 -> requester 2)
    set_req(2, 5'd9, 32'h99);
    bus.req_valid = 3'b100;
    #1;
    chk("prestall_ready", 64'(bus.req_ready), 64'(3'b100));
    step();
    bus.stall = 1'b1;
    #1;
    chk("stall_drain_we", 64'(bus.rf_we), 64'd1);
    chk("stall_drain_waddr", 64'(bus.rf_waddr), 64'd9);
    for (int c = 0; c < 3; c++) begin
      chk($sformatf("stall_ready_%0d", c), 64'(bus.req_ready), 64'd0);
      step();
      chk($sformatf("stall_we_%0d", c), 64'(bus.rf_we), 64'd0);
    end
    bus.stall = 1'b0;
    #1;
    chk("unstall_ready", 64'(bus.req_ready), 64'(3'b100));
    step();
    bus.req_valid = '0;
    #1;
    chk("unstall_we", 64'(bus.rf_we), 64'd1);
    chk("unstall_last", 64'(bus.last_grant), 64'(3'b100));

    // Consecutive writes to r7 (ptr=0)
    set_req(0, 5'd7, 32'd1);
    bus.req_valid  = 3'b001;
    bus.rd_addr_A  = 5'd7;
    bus.rf_rdata_A = 32'h0;
    bus.rd_addr_B  = 5'd3;
    bus.rf_rdata_B = 32'h33;
    #1;
    chk("r7a_ready", 64'(bus.req_ready), 64'(3'b001));
    step();
    set_req(0, 5'd7, 32'd2);
    #1;
    chk("r7a_wdata", 64'(bus.rf_wdata), 64'd1);
    chk("r7a_rdata_A", 64'(bus.rdata_A), 64'd1);
    chk("r7a_rdata_B", 64'(bus.rdata_B), 64'(32'h33));
    chk("r7b_ready", 64'(bus.req_ready), 64'(3'b001));
    step();
    bus.req_valid = '0;
    bus.rf_rdata_A = 32'd1;
    #1;
    chk("r7b_we", 64'(bus.rf_we), 64'd1);
    chk("r7b_wdata", 64'(bus.rf_wdata), 64'd2);
    chk("r7b_rdata_A", 64'(bus.rdata_A), 64'd2);

    // Mid-stream reset (ptr=1 -> requester 1 granted, ptr becomes 2)
    set_req(1, 5'd4, 32'h44);
    bus.req_valid = 3'b010;
    step();
    bus.req_valid = '0;
    #1;
    chk("mid_we_before", 64'(bus.rf_we), 64'd1);
    #1;
    rst = 1'b1;
    #1;
    chk("mid_rst_we", 64'(bus.rf_we), 64'd0);
    chk("mid_rst_last", 64'(bus.last_grant), 64'd0);
    chk("mid_rst_waddr", 64'(bus.rf_waddr), 64'd0);
    step();
    rst = 1'b0;
    bus.req_valid = 3'b110;
    #1;
    chk("mid_rst_ptr0", 64'(bus.req_ready), 64'(3'b010));
    step();
    bus.req_valid = '0;

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
